// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the 5-stage core.
// Resolves redirects and hold requests from ex and the fetch bus into a PC
// redirect plus per-stage stall/flush controls. A taken jump is followed by a
// multi-cycle flush that covers fetch latency. Consecutive held cycles are
// counted, and a runaway stall parks the unit in HALT until reset.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   jump_en_i, jump_addr_i         taken branch/jump and its target, from ex
//   hold_ex_i                      ex instruction still executing
//   hold_bus_i                     fetch bus wait
//   jump_en_o, jump_addr_o         PC redirect and target (target 0 when idle)
//   stall_pc_o/if_id_o/id_ex_o     hold the PC / pipeline registers
//   flush_if_id_o/id_ex_o          load a bubble into the pipeline registers
//   busy_o                         not in RUN
//   timeout_o                      HALT reached; sticky until reset
//
// state | meaning
// RUN   | normal operation, redirect/stall requests serviced
// FLUSH | draining wrong-path fetches after a taken jump
// HALT  | hold timeout hit, pipeline frozen until reset
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_ex_i,
  input  logic              hold_bus_i,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              stall_pc_o,
  output logic              stall_if_id_o,
  output logic              stall_id_ex_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t        state, state_nxt;
  logic [FW-1:0] flush_cnt, flush_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_nxt     = flush_cnt;
    hold_nxt      = hold_cnt;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    busy_o        = (state != RUN);
    timeout_o     = (state == HALT);

    unique case (state)
      RUN: begin
        // A held ex stage means its jump result is not valid yet.
        if (hold_ex_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
        end else if (jump_en_i) begin
          // Redirect overrides a concurrent bus wait: the fetch is discarded anyway.
          jump_en_o     = 1'b1;
          jump_addr_o   = jump_addr_i;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            flush_nxt = FW'(FLUSH_CYCLES - 1);
          end
        end else if (hold_bus_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end
      end
      FLUSH: begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        // Only completed fetches count toward draining the wrong path.
        if (hold_bus_i) begin
          stall_pc_o = 1'b1;
        end else if (flush_cnt <= FW'(1)) begin
          flush_nxt = '0;
          state_nxt = RUN;
        end else begin
          flush_nxt = flush_cnt - FW'(1);
        end
      end
      HALT: begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    // HALT is entered on the edge that closes the HOLD_TIMEOUT-th held cycle.
    if (state != HALT) begin
      if (stall_pc_o)
        hold_nxt = (hold_cnt == HW'(HOLD_TIMEOUT)) ? hold_cnt : hold_cnt + HW'(1);
      else
        hold_nxt = '0;
      if (hold_nxt == HW'(HOLD_TIMEOUT))
        state_nxt = HALT;
    end

    // Outputs are forced low for the whole reset pulse, whatever the inputs do.
    if (rst) begin
      jump_en_o     = 1'b0;
      jump_addr_o   = '0;
      stall_pc_o    = 1'b0;
      stall_if_id_o = 1'b0;
      stall_id_ex_o = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      busy_o        = 1'b0;
      timeout_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl (FLUSH_CYCLES=2, HOLD_TIMEOUT=4).
// Output bits are packed as {jump_en, stall_pc, stall_if_id, stall_id_ex,
// flush_if_id, flush_id_ex, busy, timeout}.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_ex_i;
  logic        hold_bus_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic        stall_pc_o, stall_if_id_o, stall_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, busy_o, timeout_o;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .HOLD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
            flush_if_id_o, flush_id_ex_o, busy_o, timeout_o};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp_bits, input logic [31:0] exp_addr);
    logic [7:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp_bits) else begin
      errors++;
      $error("FAIL %s outs observed=%b expected=%b", tag, obs, exp_bits);
    end
    checks++;
    assert (jump_addr_o === exp_addr) else begin
      errors++;
      $error("FAIL %s addr observed=%h expected=%h", tag, jump_addr_o, exp_addr);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check the combinational outputs.
  task automatic step(input string tag, input logic je, input logic [31:0] ja,
                      input logic hex, input logic hbus,
                      input logic [7:0] exp_bits, input logic [31:0] exp_addr);
    @(negedge clk);
    jump_en_i   = je;
    jump_addr_i = ja;
    hold_ex_i   = hex;
    hold_bus_i  = hbus;
    #1;
    check(tag, exp_bits, exp_addr);
  endtask

  initial begin
    rst = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF; hold_ex_i = 1'b1; hold_bus_i = 1'b1;
    @(negedge clk);
    #1 check("reset_all_inputs_high", 8'b0000_0000, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_ex_i = 1'b0; hold_bus_i = 1'b0;
    #1 check("run_idle_after_reset", 8'b0000_0000, 32'h0);

    // Taken jump with FLUSH_CYCLES=2
    step("jump_cycle0",   1, 32'h0000_0100, 0, 0, 8'b1000_1100, 32'h100);
    step("jump_cycle1",   0, 32'h0,         0, 0, 8'b0000_1110, 32'h0);
    step("jump_cycle2",   0, 32'h0,         0, 0, 8'b0000_0000, 32'h0);

    // hold_ex masks a concurrent jump
    step("hold_ex_masks", 1, 32'h0000_0200, 1, 0, 8'b0111_0000, 32'h0);
    step("after_hold_ex", 0, 32'h0,         0, 0, 8'b0000_0000, 32'h0);

    // Jump with bus wait: redirect wins, then bus wait stretches FLUSH
    step("jump_bus",      1, 32'h0000_0300, 0, 1, 8'b1000_1100, 32'h300);
    step("flush_wait1",   1, 32'h0000_0400, 1, 1, 8'b0100_1110, 32'h0);
    step("flush_wait2",   0, 32'h0,         0, 1, 8'b0100_1110, 32'h0);
    step("flush_wait3",   0, 32'h0,         0, 1, 8'b0100_1110, 32'h0);
    step("flush_last",    0, 32'h0,         0, 0, 8'b0000_1110, 32'h0);
    step("flush_done",    0, 32'h0,         0, 0, 8'b0000_0000, 32'h0);

    // Bus wait in RUN until HOLD_TIMEOUT=4 trips HALT
    step("bus_hold1",     0, 32'h0,         0, 1, 8'b0110_0100, 32'h0);
    step("bus_hold2",     0, 32'h0,         0, 1, 8'b0110_0100, 32'h0);
    step("bus_hold3",     0, 32'h0,         0, 1, 8'b0110_0100, 32'h0);
    step("bus_hold4",     0, 32'h0,         0, 1, 8'b0110_0100, 32'h0);
    step("halt_entered",  0, 32'h0,         0, 1, 8'b0111_0011, 32'h0);
    step("halt_sticky",   1, 32'h0000_0500, 0, 0, 8'b0111_0011, 32'h0);
    step("halt_sticky2",  0, 32'h0,         0, 0, 8'b0111_0011, 32'h0);

    // Reset clears HALT
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_from_halt", 8'b0000_0000, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("run_after_halt_rst", 8'b0000_0000, 32'h0);

    // Reset pulsed mid-FLUSH, asserted away from any clock edge
    step("jump_pre_rst",  1, 32'h0000_0600, 0, 0, 8'b1000_1100, 32'h600);
    step("flush_pre_rst", 0, 32'h0,         0, 1, 8'b0100_1110, 32'h0);
    #2 rst = 1'b1;
    #1 check("rst_async_mid_flush", 8'b0000_0000, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    hold_bus_i = 1'b0;
    #1 check("run_after_flush_rst", 8'b0000_0000, 32'h0);
    step("no_residual_flush", 0, 32'h0, 0, 0, 8'b0000_0000, 32'h0);
    step("jump_after_rst",    1, 32'h0000_0700, 0, 0, 8'b1000_1100, 32'h700);
    step("flush_after_rst",   0, 32'h0,         0, 0, 8'b0000_1110, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
